countdown_timer_core: RTL and testbench

COUNTDOWN_TIMER_CORE -- requirements
Module: countdown_timer_core

---
 rtl/countdown_timer_core.sv | 184 ++++++++++++++++++
 tb/tb_countdown_timer_core.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_core.sv
// Countdown timer / stopwatch core with BCD mm:ss digits.
// Time is set with inc pulses, then run down to 00:00 or up to MAX_MIN:59.
// Down runs can auto-reload the preset when RELOAD is 1.
module countdown_timer_core #(
    parameter int TICK_DIV = 50000000,
    parameter int MAX_MIN  = 99,
    parameter int RELOAD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       dir,
    output logic [3:0] m_dec,
    output logic [3:0] m_unit,
    output logic [3:0] s_dec,
    output logic [3:0] s_unit,
    output logic [2:0] state,
    output logic       tick,
    output logic       finish,
    output logic       done_pulse
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [3:0]      MAX_M_DEC  = 4'(MAX_MIN / 10);
    localparam logic [3:0]      MAX_M_UNIT = 4'(MAX_MIN % 10);
    localparam logic [15:0]     TIME_MAX   = {MAX_M_DEC, MAX_M_UNIT, 8'h59};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [15:0]   r_time;      // {m_dec, m_unit, s_dec, s_unit}
    logic [15:0]   r_preset;
    logic [PW-1:0] r_pre;
    logic          r_dir;
    logic          r_tick;
    logic          r_done_pulse;

    logic [7:0]    w_sec_inc;
    logic [7:0]    w_min_inc;
    logic [7:0]    w_sec_dec;
    logic [7:0]    w_min_dec;
    logic [15:0]   w_step;
    logic [15:0]   w_inc_time;
    logic          w_step_zero;
    logic          w_step_max;
    logic          w_inc_nz;

    // BCD +1 / -1 helpers for the seconds and minutes fields.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_sec_inc = {r_time[7:4], r_time[3:0] + 4'd1};
        if (r_time[3:0] == 4'd9)
            w_sec_inc = (r_time[7:4] == 4'd5) ? 8'h00 : {r_time[7:4] + 4'd1, 4'd0};

        w_min_inc = {r_time[15:12], r_time[11:8] + 4'd1};
        if (r_time[15:8] == {MAX_M_DEC, MAX_M_UNIT})
            w_min_inc = 8'h00;
        else if (r_time[11:8] == 4'd9)
            w_min_inc = {r_time[15:12] + 4'd1, 4'd0};

        w_sec_dec = {r_time[7:4], r_time[3:0] - 4'd1};
        if (r_time[3:0] == 4'd0)
            w_sec_dec = (r_time[7:4] == 4'd0) ? 8'h59 : {r_time[7:4] - 4'd1, 4'd9};

        w_min_dec = {r_time[15:12], r_time[11:8] - 4'd1};
        if (r_time[15:8] == 8'h00)
            w_min_dec = {MAX_M_DEC, MAX_M_UNIT};
        else if (r_time[11:8] == 4'd0)
            w_min_dec = {r_time[15:12] - 4'd1, 4'd9};
    end

    // One-second step in the latched direction, with carry/borrow into minutes.
    assign w_step = r_dir
        ? {(r_time[7:0] == 8'h59) ? w_min_inc : r_time[15:8], w_sec_inc}
        : {(r_time[7:0] == 8'h00) ? w_min_dec : r_time[15:8], w_sec_dec};
    assign w_step_zero = (w_step == 16'h0000);
    assign w_step_max  = (w_step == TIME_MAX);

    // Time after a set-mode increment; inc_min outranks inc_sec.
    assign w_inc_time = inc_min ? {w_min_inc, r_time[7:0]} : {r_time[15:8], w_sec_inc};
    assign w_inc_nz   = (w_inc_time != 16'h0000);

    // Command decode, prescaler and time keeping in one state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_time       <= '0;
            r_preset     <= '0;
            r_pre        <= '0;
            r_dir        <= 1'b0;
            r_tick       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_tick       <= 1'b0;
            r_done_pulse <= 1'b0;
            if (clear) begin
                r_state  <= IDLE;
                r_time   <= '0;
                r_preset <= '0;
                r_pre    <= '0;
            end else if (r_state == RUN) begin
                if (stop) begin
                    r_state <= PAUSE;
                end else if (r_pre == PRE_LAST) begin
                    r_pre  <= '0;
                    r_tick <= 1'b1;
                    if (r_dir) begin
                        r_time <= w_step;
                        if (w_step_max) begin
                            r_state      <= DONE;
                            r_done_pulse <= 1'b1;
                        end
                    end else if (w_step_zero) begin
                        r_done_pulse <= 1'b1;
                        if (RELOAD != 0) begin
                            r_time <= r_preset;
                        end else begin
                            r_time  <= w_step;
                            r_state <= DONE;
                        end
                    end else begin
                        r_time <= w_step;
                    end
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end else if (stop) begin
                if (r_state == DONE) begin
                    r_state <= IDLE;
                    r_time  <= '0;
                end
            end else if (start) begin
                case (r_state)
                    IDLE: if (dir) begin
                        r_state <= RUN;
                        r_dir   <= 1'b1;
                        r_pre   <= '0;
                    end
                    SET: begin
                        r_state  <= RUN;
                        r_dir    <= dir;
                        r_preset <= r_time;
                        r_pre    <= '0;
                    end
                    PAUSE: r_state <= RUN;
                    DONE: if (!r_dir && r_preset != 16'h0000) begin
                        r_state <= RUN;
                        r_time  <= r_preset;
                        r_pre   <= '0;
                    end
                    default: ;
                endcase
            end else if (inc_min || inc_sec) begin
                if (r_state != DONE) begin
                    r_time <= w_inc_time;
                    if (r_state != PAUSE)
                        r_state <= w_inc_nz ? SET : IDLE;
                end
            end
        end
    end

    assign m_dec      = r_time[15:12];
    assign m_unit     = r_time[11:8];
    assign s_dec      = r_time[7:4];
    assign s_unit     = r_time[3:0];
    assign state      = r_state;
    assign tick       = r_tick;
    assign finish     = (r_state == DONE);
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: directed scenarios plus random commands
// checked against a seconds-based behavioural model (RELOAD 0 and 1 instances).
module tb_countdown_timer_core;

    localparam int TD      = 4;
    localparam int MM      = 99;
    localparam int MAXT    = MM * 60 + 59;
    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic inc_sec = 1'b0, inc_min = 1'b0, dir = 1'b0;

    logic [3:0] md0, mu0, sd0, su0, md1, mu1, sd1, su1;
    logic [2:0] st0, st1;
    logic       tk0, fi0, dp0, tk1, fi1, dp1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    countdown_timer_core #(.TICK_DIV(TD), .MAX_MIN(MM), .RELOAD(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .inc_sec(inc_sec), .inc_min(inc_min), .dir(dir),
        .m_dec(md0), .m_unit(mu0), .s_dec(sd0), .s_unit(su0),
        .state(st0), .tick(tk0), .finish(fi0), .done_pulse(dp0)
    );

    countdown_timer_core #(.TICK_DIV(TD), .MAX_MIN(MM), .RELOAD(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .inc_sec(inc_sec), .inc_min(inc_min), .dir(dir),
        .m_dec(md1), .m_unit(mu1), .s_dec(sd1), .s_unit(su1),
        .state(st1), .tick(tk1), .finish(fi1), .done_pulse(dp1)
    );

    typedef struct {
        int st;
        int t;       // time in whole seconds
        int preset;
        int pre;
        bit d;
        bit tick;
        bit dp;
    } mdl_t;

    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Next model state after one clock, given this cycle's commands.
    function automatic mdl_t model_next(input mdl_t s, input bit rl, input bit c_clear,
                                        input bit c_stop, input bit c_start, input bit c_imin,
                                        input bit c_isec, input bit c_dir);
        mdl_t n;
        int mi, se;
        n = s;
        n.tick = 1'b0;
        n.dp = 1'b0;
        mi = s.t / 60;
        se = s.t % 60;
        if (c_clear) begin
            n.st = S_IDLE; n.t = 0; n.preset = 0; n.pre = 0;
        end else if (s.st == S_RUN) begin
            if (c_stop) begin
                n.st = S_PAUSE;
            end else if (s.pre == TD - 1) begin
                n.pre = 0;
                n.tick = 1'b1;
                if (s.d) begin
                    n.t = (s.t == MAXT) ? 0 : s.t + 1;
                    if (n.t == MAXT) begin n.st = S_DONE; n.dp = 1'b1; end
                end else begin
                    n.t = (s.t == 0) ? MAXT : s.t - 1;
                    if (n.t == 0) begin
                        n.dp = 1'b1;
                        if (rl) n.t = s.preset;
                        else    n.st = S_DONE;
                    end
                end
            end else begin
                n.pre = s.pre + 1;
            end
        end else if (c_stop) begin
            if (s.st == S_DONE) begin n.st = S_IDLE; n.t = 0; end
        end else if (c_start) begin
            if (s.st == S_IDLE && c_dir) begin
                n.st = S_RUN; n.d = 1'b1; n.pre = 0;
            end else if (s.st == S_SET) begin
                n.st = S_RUN; n.d = c_dir; n.preset = s.t; n.pre = 0;
            end else if (s.st == S_PAUSE) begin
                n.st = S_RUN;
            end else if (s.st == S_DONE && !s.d && s.preset != 0) begin
                n.st = S_RUN; n.t = s.preset; n.pre = 0;
            end
        end else if (c_imin || c_isec) begin
            if (s.st != S_DONE) begin
                n.t = c_imin ? ((mi + 1) % (MM + 1)) * 60 + se : mi * 60 + (se + 1) % 60;
                if (s.st != S_PAUSE) n.st = (n.t != 0) ? S_SET : S_IDLE;
            end
        end
        return n;
    endfunction

    // Drive one cycle of command pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic c_clear, input logic c_stop, input logic c_start,
                       input logic c_imin, input logic c_isec, input logic c_dir);
        clear = c_clear; stop = c_stop; start = c_start;
        inc_min = c_imin; inc_sec = c_isec; dir = c_dir;
        @(posedge clk);
        #1;
        clear = 1'b0; stop = 1'b0; start = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dir);
    endtask

    // Idle until the selected instance shows tick, up to budget cycles.
    task automatic wait_tick(input bit sel, input int budget, output int n, output bit found);
        found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            idle_cyc();
            n++;
            if ((sel ? tk1 : tk0) === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        total++;
        if ({st0, md0, mu0, sd0, su0, tk0, fi0, dp0} !== 22'd0)
            $display("FAIL reset_state0: got %h expected 0", {st0, md0, mu0, sd0, su0, tk0, fi0, dp0});
        else passed++;
        total++;
        if ({st1, md1, mu1, sd1, su1, tk1, fi1, dp1} !== 22'd0)
            $display("FAIL reset_state1: got %h expected 0", {st1, md1, mu1, sd1, su1, tk1, fi1, dp1});
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({st0, md0, mu0, sd0, su0, tk0, fi0, dp0} !== 22'd0)
            $display("FAIL reset_held: got %h expected 0", {st0, md0, mu0, sd0, su0, tk0, fi0, dp0});
        else passed++;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_countdown();
        int n;
        bit found;
        int dps;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        total++;
        if ({st0, md0, mu0, sd0, su0} !== {3'(S_SET), to_bcd(62)})
            $display("FAIL cd_set: got %h expected %h", {st0, md0, mu0, sd0, su0}, {3'(S_SET), to_bcd(62)});
        else passed++;
        cyc(0, 0, 1, 0, 0, 0);
        total++;
        if (st0 !== 3'(S_RUN)) $display("FAIL cd_start: got %0d expected %0d", st0, S_RUN);
        else passed++;
        dps = 0;
        for (int k = 1; k <= 62; k++) begin
            wait_tick(0, 8, n, found);
            total++;
            if (!found || n != 4) $display("FAIL cd_tick_period k=%0d: got %0d found=%0d expected 4", k, n, found);
            else passed++;
            total++;
            if ({md0, mu0, sd0, su0} !== to_bcd(62 - k))
                $display("FAIL cd_digits k=%0d: got %h expected %h", k, {md0, mu0, sd0, su0}, to_bcd(62 - k));
            else passed++;
            total++;
            if (dp0 !== (k == 62) || fi0 !== (k == 62))
                $display("FAIL cd_done k=%0d: got dp=%0d fin=%0d expected %0d", k, dp0, fi0, (k == 62));
            else passed++;
            if (dp0 === 1'b1) dps++;
        end
        total++;
        if (st0 !== 3'(S_DONE) || dps != 1)
            $display("FAIL cd_final: got state=%0d pulses=%0d expected state=4 pulses=1", st0, dps);
        else passed++;
        idle_cyc();
        total++;
        if ({st0, fi0, dp0} !== {3'(S_DONE), 1'b1, 1'b0})
            $display("FAIL cd_hold_done: got %b expected %b", {st0, fi0, dp0}, {3'(S_DONE), 1'b1, 1'b0});
        else passed++;
        cyc(0, 0, 1, 0, 0, 0);
        total++;
        if ({st0, md0, mu0, sd0, su0} !== {3'(S_RUN), to_bcd(62)})
            $display("FAIL cd_restart: got %h expected %h", {st0, md0, mu0, sd0, su0}, {3'(S_RUN), to_bcd(62)});
        else passed++;
        cyc(0, 1, 0, 0, 0, 0);
        total++;
        if (st0 !== 3'(S_PAUSE)) $display("FAIL cd_stop: got %0d expected %0d", st0, S_PAUSE);
        else passed++;
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_inc_wrap();
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            total++;
            if ({st0, md0, mu0, sd0, su0} !== {3'((k < 60) ? S_SET : S_IDLE), to_bcd(k % 60)})
                $display("FAIL inc_wrap k=%0d: got %h expected %h", k, {st0, md0, mu0, sd0, su0},
                         {3'((k < 60) ? S_SET : S_IDLE), to_bcd(k % 60)});
            else passed++;
        end
    endtask

    task automatic test_pause();
        int n;
        bit found;
        bit bad;
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        wait_tick(0, 8, n, found);
        total++;
        if (!found || n != 4 || {md0, mu0, sd0, su0} !== to_bcd(2))
            $display("FAIL pause_first_tick: got n=%0d digits=%h expected 4 %h", n, {md0, mu0, sd0, su0}, to_bcd(2));
        else passed++;
        idle_cyc();
        cyc(0, 1, 0, 0, 0, 0);
        total++;
        if (st0 !== 3'(S_PAUSE)) $display("FAIL pause_enter: got %0d expected %0d", st0, S_PAUSE);
        else passed++;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_cyc();
            if ({md0, mu0, sd0, su0} !== to_bcd(2) || tk0 !== 1'b0 || st0 !== 3'(S_PAUSE)) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL pause_frozen: got digits=%h tick=%0d expected %h 0", {md0, mu0, sd0, su0}, tk0, to_bcd(2));
        else passed++;
        cyc(0, 0, 1, 0, 0, 0);
        wait_tick(0, 8, n, found);
        total++;
        if (!found || n != 3 || {md0, mu0, sd0, su0} !== to_bcd(1))
            $display("FAIL pause_resume: got n=%0d digits=%h expected 3 %h", n, {md0, mu0, sd0, su0}, to_bcd(1));
        else passed++;
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reload();
        int n;
        bit found;
        cyc(1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            wait_tick(1, 8, n, found);
            total++;
            if (!found || n != 4 || {md1, mu1, sd1, su1} !== to_bcd((k % 2 == 1) ? 1 : 2))
                $display("FAIL reload_digits k=%0d: got n=%0d %h expected 4 %h", k, n, {md1, mu1, sd1, su1},
                         to_bcd((k % 2 == 1) ? 1 : 2));
            else passed++;
            total++;
            if ({st1, fi1, dp1} !== {3'(S_RUN), 1'b0, (k % 2 == 0)})
                $display("FAIL reload_status k=%0d: got %b expected %b", k, {st1, fi1, dp1},
                         {3'(S_RUN), 1'b0, (k % 2 == 0)});
            else passed++;
        end
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_up_and_clear();
        int n;
        bit found;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        total++;
        if (st0 !== 3'(S_IDLE)) $display("FAIL idle_down_start: got %0d expected %0d", st0, S_IDLE);
        else passed++;
        cyc(0, 0, 1, 0, 0, 1);
        wait_tick(0, 8, n, found);
        total++;
        if (!found || st0 !== 3'(S_RUN) || {md0, mu0, sd0, su0} !== to_bcd(1))
            $display("FAIL idle_up_run: got state=%0d %h expected 2 %h", st0, {md0, mu0, sd0, su0}, to_bcd(1));
        else passed++;
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        repeat (99) cyc(0, 0, 0, 1, 0, 1);
        repeat (58) cyc(0, 0, 0, 0, 1, 1);
        total++;
        if ({st0, md0, mu0, sd0, su0} !== {3'(S_SET), to_bcd(99 * 60 + 58)})
            $display("FAIL up_set: got %h expected %h", {st0, md0, mu0, sd0, su0}, {3'(S_SET), to_bcd(99 * 60 + 58)});
        else passed++;
        cyc(0, 0, 1, 0, 0, 1);
        wait_tick(0, 8, n, found);
        total++;
        if (!found || {st0, md0, mu0, sd0, su0, fi0, dp0} !== {3'(S_DONE), to_bcd(MAXT), 2'b11})
            $display("FAIL up_done: got %h expected %h", {st0, md0, mu0, sd0, su0, fi0, dp0},
                     {3'(S_DONE), to_bcd(MAXT), 2'b11});
        else passed++;
        cyc(1, 0, 1, 0, 0, 1);
        total++;
        if ({st0, md0, mu0, sd0, su0, fi0} !== 20'd0)
            $display("FAIL clear_beats_start: got %h expected 0", {st0, md0, mu0, sd0, su0, fi0});
        else passed++;
        dir = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit found;
        cyc(1, 0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        wait_tick(0, 8, n, found);
        total++;
        if (!found) $display("FAIL rst_run_tick: got none expected tick");
        else passed++;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({st0, md0, mu0, sd0, su0, tk0, fi0, dp0, st1, md1, mu1, sd1, su1, tk1, fi1, dp1} !== 44'd0)
            $display("FAIL rst_async: got %h / %h expected 0", {st0, md0, mu0, sd0, su0, tk0, fi0, dp0},
                     {st1, md1, mu1, sd1, su1, tk1, fi1, dp1});
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({st0, md0, mu0, sd0, su0, tk0, fi0, dp0} !== 22'd0)
            $display("FAIL rst_hold: got %h expected 0", {st0, md0, mu0, sd0, su0, tk0, fi0, dp0});
        else passed++;
        @(negedge clk) reset = 1'b1;
        cyc(0, 0, 0, 0, 1, 0);
        total++;
        if ({st0, md0, mu0, sd0, su0} !== {3'(S_SET), to_bcd(1)})
            $display("FAIL rst_release: got %h expected %h", {st0, md0, mu0, sd0, su0}, {3'(S_SET), to_bcd(1)});
        else passed++;
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        mdl_t m0, m1, n0, n1;
        bit c_clear, c_stop, c_start, c_imin, c_isec, c_dir;
        logic [21:0] exp0, exp1;
        m0 = '{S_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        m1 = m0;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            c_clear = ($urandom_range(0, 199) == 0);
            c_stop  = ($urandom_range(0, 29) == 0);
            c_start = ($urandom_range(0, 7) == 0);
            c_imin  = ($urandom_range(0, 39) == 0);
            c_isec  = ($urandom_range(0, 5) == 0);
            c_dir   = 1'($urandom_range(0, 1));
            n0 = model_next(m0, 1'b0, c_clear, c_stop, c_start, c_imin, c_isec, c_dir);
            n1 = model_next(m1, 1'b1, c_clear, c_stop, c_start, c_imin, c_isec, c_dir);
            cyc(c_clear, c_stop, c_start, c_imin, c_isec, c_dir);
            m0 = n0;
            m1 = n1;
            exp0 = {3'(m0.st), to_bcd(m0.t), m0.tick, (m0.st == S_DONE), m0.dp};
            exp1 = {3'(m1.st), to_bcd(m1.t), m1.tick, (m1.st == S_DONE), m1.dp};
            total++;
            if ({st0, md0, mu0, sd0, su0, tk0, fi0, dp0} !== exp0)
                $display("FAIL rand0 cycle %0d: got %h expected %h", i, {st0, md0, mu0, sd0, su0, tk0, fi0, dp0}, exp0);
            else passed++;
            total++;
            if ({st1, md1, mu1, sd1, su1, tk1, fi1, dp1} !== exp1)
                $display("FAIL rand1 cycle %0d: got %h expected %h", i, {st1, md1, mu1, sd1, su1, tk1, fi1, dp1}, exp1);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_inc_wrap();
        test_pause();
        test_reload();
        test_up_and_clear();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
